// File: rtl/axi4_defs.sv
// AXI4 encodings and fixed read-channel attributes shared by the VDMA frame reader.
package axi4_defs;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] PROT_DEFAULT  = 3'b000;
    localparam logic [3:0] QOS_DEFAULT   = 4'b0000;

    typedef enum logic [1:0] {
        StIdle,
        StAr,
        StDrain
    } rd_state_e;

endpackage

// File: rtl/vdma_fifo_sync.sv
// Synchronous FIFO with a registered output stage; count covers storage plus the output register.
module vdma_fifo_sync #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PTR_WIDTH  = 6
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [PTR_WIDTH+1:0]  count
);

    localparam int unsigned DEPTH = 1 << PTR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_WIDTH:0]    mem_cnt_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  pop, load;

    // Refill the output register whenever it is empty or being consumed.
    always_comb begin
        pop  = rd_en && out_valid_q;
        load = (mem_cnt_q != '0) && (!out_valid_q || pop);
    end

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
            if (load) begin
                out_data_q  <= mem[rd_ptr_q];
                out_valid_q <= 1'b1;
                rd_ptr_q    <= rd_ptr_q + PTR_WIDTH'(1);
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
            mem_cnt_q <= mem_cnt_q + (PTR_WIDTH+1)'(wr_en) - (PTR_WIDTH+1)'(load);
        end
    end

    assign rd_data  = out_data_q;
    assign rd_valid = out_valid_q;
    assign count    = (PTR_WIDTH+2)'(mem_cnt_q) + (PTR_WIDTH+2)'(out_valid_q);

endmodule

// File: rtl/vdma_axi4_frame_reader.sv
// AXI4 read master fetching a 2-D frame into a credit-limited FIFO and replaying it as AXI4-Stream video.
module vdma_axi4_frame_reader
    import axi4_defs::*;
#(
    parameter int unsigned             AXI_ID_WIDTH   = 4,
    parameter logic [AXI_ID_WIDTH-1:0] AXI_ID         = '0,
    parameter int unsigned             AXI_ADDR_WIDTH = 32,
    parameter int unsigned             AXI_LEN_WIDTH  = 8,
    parameter int unsigned             AXI_DATA_SIZE  = 2,
    parameter int unsigned             AXI_DATA_WIDTH = (8 << AXI_DATA_SIZE),
    parameter int unsigned             MAX_BURST      = 16,
    parameter int unsigned             H_WIDTH        = 12,
    parameter int unsigned             V_WIDTH        = 12,
    parameter int unsigned             FIFO_PTR_WIDTH = 6
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      ctl_enable,
    input  logic [AXI_ADDR_WIDTH-1:0] param_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] param_stride,
    input  logic [H_WIDTH-1:0]        param_width,
    input  logic [V_WIDTH-1:0]        param_height,
    output logic                      status_busy,
    output logic                      status_rresp_err,
    output logic [AXI_ID_WIDTH-1:0]   m_axi4_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi4_araddr,
    output logic [AXI_LEN_WIDTH-1:0]  m_axi4_arlen,
    output logic [2:0]                m_axi4_arsize,
    output logic [1:0]                m_axi4_arburst,
    output logic                      m_axi4_arlock,
    output logic [3:0]                m_axi4_arcache,
    output logic [2:0]                m_axi4_arprot,
    output logic [3:0]                m_axi4_arqos,
    output logic                      m_axi4_arvalid,
    input  logic                      m_axi4_arready,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi4_rid,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata,
    input  logic [1:0]                m_axi4_rresp,
    input  logic                      m_axi4_rlast,
    input  logic                      m_axi4_rvalid,
    output logic                      m_axi4_rready,
    output logic                      m_axis_tuser,
    output logic                      m_axis_tlast,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready
);

    localparam int unsigned DEPTH = 1 << FIFO_PTR_WIDTH;
    localparam int unsigned CW0   = (H_WIDTH > 13) ? H_WIDTH : 13;
    localparam int unsigned CW    = ((CW0 > FIFO_PTR_WIDTH + 2) ? CW0 : FIFO_PTR_WIDTH + 2) + 1;

    rd_state_e                 state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] line_base_q, line_base_d, addr_q, addr_d, stride_q, stride_d;
    logic [H_WIDTH-1:0]        width_q, width_d, h_left_q, h_left_d, h_q, h_d;
    logic [V_WIDTH-1:0]        height_q, height_d, v_left_q, v_left_d, v_q, v_d;
    logic [CW-1:0]             outstanding_q, outstanding_d;
    logic                      err_q, err_d;

    logic [CW-1:0]             to_4k, burst_len, credit_free;
    logic [FIFO_PTR_WIDTH+1:0] fifo_count;
    logic                      ar_fire, r_fire, pop, line_end, frame_end, unused_r;

    assign unused_r = ^{m_axi4_rid, m_axi4_rlast};

    vdma_fifo_sync #(
        .DATA_WIDTH(AXI_DATA_WIDTH),
        .PTR_WIDTH (FIFO_PTR_WIDTH)
    ) u_fifo (
        .aclk    (aclk),
        .areset  (areset),
        .wr_en   (r_fire),
        .wr_data (m_axi4_rdata),
        .rd_en   (m_axis_tready),
        .rd_data (m_axis_tdata),
        .rd_valid(m_axis_tvalid),
        .count   (fifo_count)
    );

    // Burst length only depends on registered state, so arvalid/araddr/arlen hold until accepted.
    always_comb begin
        to_4k     = (CW'(4096) - CW'(addr_q[11:0])) >> AXI_DATA_SIZE;
        burst_len = CW'(MAX_BURST);
        if (CW'(h_left_q) < burst_len) burst_len = CW'(h_left_q);
        if (to_4k < burst_len) burst_len = to_4k;
        // Credits cover both beats in flight and beats sitting in the FIFO.
        credit_free = CW'(DEPTH) - CW'(fifo_count) - outstanding_q;
    end

    assign status_busy      = (state_q != StIdle);
    assign status_rresp_err = err_q;
    assign m_axi4_arid      = AXI_ID;
    assign m_axi4_araddr    = addr_q;
    assign m_axi4_arlen     = AXI_LEN_WIDTH'(burst_len - CW'(1));
    assign m_axi4_arsize    = 3'(AXI_DATA_SIZE);
    assign m_axi4_arburst   = BURST_INCR;
    assign m_axi4_arlock    = 1'b0;
    assign m_axi4_arcache   = CACHE_DEFAULT;
    assign m_axi4_arprot    = PROT_DEFAULT;
    assign m_axi4_arqos     = QOS_DEFAULT;
    assign m_axi4_arvalid   = (state_q == StAr) && (credit_free >= burst_len);
    assign m_axi4_rready    = status_busy;
    assign m_axis_tuser     = m_axis_tvalid && (h_q == '0) && (v_q == '0);
    assign m_axis_tlast     = m_axis_tvalid && line_end;

    assign ar_fire   = m_axi4_arvalid && m_axi4_arready;
    assign r_fire    = m_axi4_rvalid && m_axi4_rready;
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign line_end  = (h_q == width_q - H_WIDTH'(1));
    assign frame_end = pop && line_end && (v_q == height_q - V_WIDTH'(1));

    always_comb begin
        state_d       = state_q;
        line_base_d   = line_base_q;
        addr_d        = addr_q;
        stride_d      = stride_q;
        width_d       = width_q;
        height_d      = height_q;
        h_left_d      = h_left_q;
        v_left_d      = v_left_q;
        err_d         = err_q;
        h_d           = h_q;
        v_d           = v_q;
        outstanding_d = outstanding_q + (ar_fire ? burst_len : '0) - CW'(r_fire);

        if (r_fire && (m_axi4_rresp != RESP_OKAY)) err_d = 1'b1;

        if (pop) begin
            if (line_end) begin
                h_d = '0;
                v_d = frame_end ? '0 : v_q + V_WIDTH'(1);
            end else begin
                h_d = h_q + H_WIDTH'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (ctl_enable && (param_width != '0) && (param_height != '0)) begin
                    line_base_d = param_addr;
                    addr_d      = param_addr;
                    stride_d    = param_stride;
                    width_d     = param_width;
                    height_d    = param_height;
                    h_left_d    = param_width;
                    v_left_d    = param_height;
                    err_d       = 1'b0;
                    h_d         = '0;
                    v_d         = '0;
                    state_d     = StAr;
                end
            end
            StAr: begin
                if (ar_fire) begin
                    addr_d   = addr_q + (AXI_ADDR_WIDTH'(burst_len) << AXI_DATA_SIZE);
                    h_left_d = h_left_q - H_WIDTH'(burst_len);
                    if (CW'(h_left_q) == burst_len) begin
                        if (v_left_q == V_WIDTH'(1)) begin
                            state_d = StDrain;
                        end else begin
                            line_base_d = line_base_q + stride_q;
                            addr_d      = line_base_q + stride_q;
                            h_left_d    = width_q;
                            v_left_d    = v_left_q - V_WIDTH'(1);
                        end
                    end
                end
            end
            StDrain: begin
                if (frame_end) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= StIdle;
            line_base_q   <= '0;
            addr_q        <= '0;
            stride_q      <= '0;
            width_q       <= '0;
            height_q      <= '0;
            h_left_q      <= '0;
            v_left_q      <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
        end else begin
            state_q       <= state_d;
            line_base_q   <= line_base_d;
            addr_q        <= addr_d;
            stride_q      <= stride_d;
            width_q       <= width_d;
            height_q      <= height_d;
            h_left_q      <= h_left_d;
            v_left_q      <= v_left_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            h_q           <= h_d;
            v_q           <= v_d;
        end
    end

endmodule

// File: tb/tb_vdma_axi4_frame_reader.sv
// Directed bench for the VDMA frame reader with an inline memory slave holding mem[i]=i.
module tb_vdma_axi4_frame_reader;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        ctl_enable = 1'b0;
    logic [31:0] param_addr = '0, param_stride = '0;
    logic [11:0] param_width = '0, param_height = '0;
    logic        status_busy, status_rresp_err;
    logic [3:0]  arid, arcache, arqos;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst;
    logic        arlock, arvalid;
    logic        arready = 1'b0;
    logic [3:0]  rid = '0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0, rvalid = 1'b0;
    logic        rready;
    logic        tuser, tlast, tvalid;
    logic [31:0] tdata;
    logic        tready = 1'b1;

    always #5 aclk = ~aclk;

    vdma_axi4_frame_reader dut (
        .aclk(aclk), .areset(areset), .ctl_enable(ctl_enable),
        .param_addr(param_addr), .param_stride(param_stride),
        .param_width(param_width), .param_height(param_height),
        .status_busy(status_busy), .status_rresp_err(status_rresp_err),
        .m_axi4_arid(arid), .m_axi4_araddr(araddr), .m_axi4_arlen(arlen),
        .m_axi4_arsize(arsize), .m_axi4_arburst(arburst), .m_axi4_arlock(arlock),
        .m_axi4_arcache(arcache), .m_axi4_arprot(arprot), .m_axi4_arqos(arqos),
        .m_axi4_arvalid(arvalid), .m_axi4_arready(arready),
        .m_axi4_rid(rid), .m_axi4_rdata(rdata), .m_axi4_rresp(rresp),
        .m_axi4_rlast(rlast), .m_axi4_rvalid(rvalid), .m_axi4_rready(rready),
        .m_axis_tuser(tuser), .m_axis_tlast(tlast), .m_axis_tdata(tdata),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] stride;
        int          width;
        int          height;
        int          tr_pct;
        int          exp_ars;
        logic [31:0] a0, a1, a2;
        int          l0, l1, l2;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Scoreboard / slave state
    logic [31:0] cfg_addr, cfg_stride;
    int          cfg_width, cfg_height, tr_pct, err_word;
    int          sb_h, sb_v, beats_seen, frames_done, credits_used;
    bit          busy_at_end, s_busy, s_err;
    logic [31:0] ar_addr_q[$];
    int          ar_len_q[$];
    logic [31:0] sq_addr[$];
    int          sq_len[$];
    int          r_beat;
    bit          ar_hold, t_hold, hold_user, hold_last;
    logic [31:0] hold_addr, hold_data;
    logic [7:0]  hold_len;

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive_r();
        int word;
        if (sq_addr.size() != 0) begin
            word   = int'(((sq_addr[0] >> 2) + 32'(r_beat)) % 32'd4096);
            rvalid = 1'b1;
            rdata  = 32'(word);
            rresp  = (word == err_word) ? 2'b10 : 2'b00;
            rlast  = (r_beat == sq_len[0]);
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
            rresp  = 2'b00;
            rlast  = 1'b0;
        end
    endtask

    task automatic clear_state();
        sq_addr.delete(); sq_len.delete(); ar_addr_q.delete(); ar_len_q.delete();
        r_beat = 0; sb_h = 0; sb_v = 0; beats_seen = 0; frames_done = 0; credits_used = 0;
        ar_hold = 0; t_hold = 0; busy_at_end = 0;
        drive_r();
    endtask

    task automatic set_cfg(input logic [31:0] a, input logic [31:0] s, input int w, input int h);
        cfg_addr = a; cfg_stride = s; cfg_width = w; cfg_height = h;
        param_addr = a; param_stride = s; param_width = 12'(w); param_height = 12'(h);
        sb_h = 0; sb_v = 0; beats_seen = 0; frames_done = 0;
        ar_addr_q.delete(); ar_len_q.delete();
    endtask

    task automatic cycle();
        bit ar_hs, r_hs, t_hs;
        logic [31:0] la, cap_addr;
        int word, cap_len;
        @(negedge aclk);
        s_busy = status_busy;
        s_err  = status_rresp_err;
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
        t_hs  = tvalid && tready;
        cap_addr = araddr;
        cap_len  = int'(arlen);
        if (status_busy) check_eq("rready_busy", rready, 1);
        if (arvalid) check_eq("ar_credit", (credits_used + cap_len + 1 <= 64), 1);
        if (ar_hold) begin
            check_eq("ar_hold_valid", arvalid, 1);
            check_eq("ar_hold_addr", araddr, hold_addr);
            check_eq("ar_hold_len", arlen, hold_len);
        end
        if (t_hold) begin
            check_eq("t_hold_valid", tvalid, 1);
            check_eq("t_hold_data", tdata, hold_data);
            check_eq("t_hold_user", tuser, hold_user);
            check_eq("t_hold_last", tlast, hold_last);
        end
        ar_hold = arvalid && !arready; hold_addr = araddr; hold_len = arlen;
        t_hold = tvalid && !tready; hold_data = tdata; hold_user = tuser; hold_last = tlast;
        if (ar_hs) begin
            ar_addr_q.push_back(cap_addr);
            ar_len_q.push_back(cap_len);
            credits_used += cap_len + 1;
        end
        if (t_hs) begin
            la   = cfg_addr + cfg_stride * 32'(sb_v);
            word = int'(((la >> 2) + 32'(sb_h)) % 32'd4096);
            check_eq("tdata", tdata, word);
            check_eq("tuser", tuser, (sb_h == 0 && sb_v == 0));
            check_eq("tlast", tlast, (sb_h == cfg_width - 1));
            credits_used--;
            beats_seen++;
            if (sb_h == cfg_width - 1) begin
                sb_h = 0;
                if (sb_v == cfg_height - 1) begin
                    sb_v = 0;
                    frames_done++;
                    busy_at_end = status_busy;
                end else begin
                    sb_v++;
                end
            end else begin
                sb_h++;
            end
        end
        @(posedge aclk);
        #1;
        if (ar_hs) begin
            sq_addr.push_back(cap_addr);
            sq_len.push_back(cap_len);
        end
        if (r_hs) begin
            if (r_beat == sq_len[0]) begin
                void'(sq_addr.pop_front());
                void'(sq_len.pop_front());
                r_beat = 0;
            end else begin
                r_beat++;
            end
        end
        drive_r();
        arready = ($urandom_range(3) != 0);
        tready  = (tr_pct == 0) ? 1'b1 : ($urandom_range(99) >= tr_pct);
    endtask

    task automatic run_frames(input int target, input bit drop_on_busy, input string name);
        int n = 0;
        while (!(frames_done >= target && !status_busy) && n < 4000) begin
            cycle();
            if (drop_on_busy && status_busy) ctl_enable = 1'b0;
            n++;
        end
        check_eq({name, "_timeout"}, (n < 4000), 1);
    endtask

    vec_t vecs[4];

    initial begin
        int n;
        int busy_cnt;
        vecs[0] = '{32'h0, 32'd64, 16, 4, 0, 4, 32'h0, 32'd64, 32'd128, 15, 15, 15};
        vecs[1] = '{32'h0, 32'd160, 40, 2, 0, 6, 32'h0, 32'd64, 32'd128, 15, 15, 7};
        vecs[2] = '{32'hFF8, 32'd64, 8, 1, 0, 2, 32'hFF8, 32'h1000, 32'h0, 1, 5, 0};
        vecs[3] = '{32'h100, 32'h80, 16, 8, 30, 8, 32'h100, 32'h180, 32'h200, 15, 15, 15};
        tr_pct = 0;
        err_word = -1;
        clear_state();

        // Reset state
        #3;
        check_eq("rst_arvalid", arvalid, 0);
        check_eq("rst_rready", rready, 0);
        check_eq("rst_tvalid", tvalid, 0);
        check_eq("rst_tuser", tuser, 0);
        check_eq("rst_tlast", tlast, 0);
        check_eq("rst_busy", status_busy, 0);
        check_eq("rst_err", status_rresp_err, 0);
        check_eq("arsize", arsize, 2);
        check_eq("arburst", arburst, 1);
        check_eq("arcache", arcache, 3);
        check_eq("arlock_prot_qos_id", {arlock, arprot, arqos, arid}, 0);
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;

        // Table-driven frames
        for (int i = 0; i < 4; i++) begin
            set_cfg(vecs[i].addr, vecs[i].stride, vecs[i].width, vecs[i].height);
            tr_pct = vecs[i].tr_pct;
            ctl_enable = 1'b1;
            run_frames(1, 1'b1, "vec");
            repeat (10) cycle();
            check_eq("vec_ars", ar_addr_q.size(), vecs[i].exp_ars);
            check_eq("vec_beats", beats_seen, vecs[i].width * vecs[i].height);
            check_eq("vec_frames", frames_done, 1);
            check_eq("vec_err", s_err, 0);
            if (ar_addr_q.size() >= 2) begin
                check_eq("vec_a0", ar_addr_q[0], vecs[i].a0);
                check_eq("vec_l0", ar_len_q[0], vecs[i].l0);
                check_eq("vec_a1", ar_addr_q[1], vecs[i].a1);
                check_eq("vec_l1", ar_len_q[1], vecs[i].l1);
            end
            if (vecs[i].exp_ars > 2 && ar_addr_q.size() >= 3) begin
                check_eq("vec_a2", ar_addr_q[2], vecs[i].a2);
                check_eq("vec_l2", ar_len_q[2], vecs[i].l2);
            end
        end
        tr_pct = 0;

        // Zero width / zero height never start a frame
        set_cfg(32'h0, 32'd64, 0, 4);
        ctl_enable = 1'b1;
        busy_cnt = 0;
        repeat (8) begin cycle(); busy_cnt += int'(s_busy); end
        param_width = 12'd4; param_height = 12'd0;
        repeat (8) begin cycle(); busy_cnt += int'(s_busy); end
        ctl_enable = 1'b0;
        check_eq("zero_dim_busy", busy_cnt, 0);
        check_eq("zero_dim_ars", ar_addr_q.size(), 0);

        // Enable dropped during line 2: frame completes, busy falls right after last tlast
        set_cfg(32'h0, 32'd64, 16, 4);
        ctl_enable = 1'b1;
        n = 0;
        while (sb_v < 2 && n < 2000) begin cycle(); n++; end
        check_eq("drop_reach_line2", sb_v, 2);
        ctl_enable = 1'b0;
        run_frames(1, 1'b0, "drop");
        check_eq("drop_busy_at_last", busy_at_end, 1);
        cycle();
        check_eq("drop_busy_after", s_busy, 0);
        repeat (20) cycle();
        check_eq("drop_ars", ar_addr_q.size(), 4);
        check_eq("drop_beats", beats_seen, 64);

        // rresp error is sticky, data still delivered; back-to-back restart clears it
        set_cfg(32'h40, 32'd64, 16, 1);
        err_word = 21;
        ctl_enable = 1'b1;
        n = 0;
        while (frames_done < 1 && n < 2000) begin cycle(); n++; end
        check_eq("err_frame1_done", frames_done, 1);
        cycle();
        check_eq("restart_gap_busy", s_busy, 0);
        check_eq("err_sticky", s_err, 1);
        cycle();
        check_eq("restart_busy", s_busy, 1);
        check_eq("restart_err_clear", s_err, 0);
        ctl_enable = 1'b0;
        run_frames(2, 1'b0, "restart");
        repeat (3) cycle();
        check_eq("restart_err_again", s_err, 1);
        check_eq("restart_beats", beats_seen, 32);
        err_word = -1;

        // Asynchronous reset mid-burst, then clean restart
        set_cfg(32'h0, 32'd64, 16, 4);
        ctl_enable = 1'b1;
        n = 0;
        while (beats_seen < 10 && n < 2000) begin cycle(); n++; end
        #2 areset = 1'b1;
        #1;
        check_eq("arst_arvalid", arvalid, 0);
        check_eq("arst_rready", rready, 0);
        check_eq("arst_tvalid", tvalid, 0);
        check_eq("arst_tuser", tuser, 0);
        check_eq("arst_tlast", tlast, 0);
        check_eq("arst_busy", status_busy, 0);
        ctl_enable = 1'b0;
        clear_state();
        set_cfg(32'h0, 32'd64, 16, 4);
        @(posedge aclk);
        #1 areset = 1'b0;
        ctl_enable = 1'b1;
        run_frames(1, 1'b1, "arst");
        repeat (5) cycle();
        check_eq("arst_frames", frames_done, 1);
        check_eq("arst_beats", beats_seen, 64);
        check_eq("arst_ars", ar_addr_q.size(), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
